// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island types and period timing constants.
package hdmi_pkg;

   typedef enum logic [1:0] {
      TMDS_CONTROL     = 2'd0,
      TMDS_DI_PREAMBLE = 2'd1,
      TMDS_DI_GUARD    = 2'd2,
      TMDS_DI_DATA     = 2'd3
   } tmds_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD,
      ST_PREAMBLE,
      ST_GUARD_LEAD,
      ST_PACKET,
      ST_GUARD_TRAIL
   } di_state_t;

   localparam int PREAMBLE_LEN   = 8;
   localparam int GUARD_LEN      = 2;
   localparam int PACKET_LEN     = 32;
   localparam int DI_MAX_PACKETS = 18;

   function automatic tmds_mode_t state_mode(input di_state_t s);
      case (s)
         ST_PREAMBLE:                   return TMDS_DI_PREAMBLE;
         ST_GUARD_LEAD, ST_GUARD_TRAIL: return TMDS_DI_GUARD;
         ST_PACKET:                     return TMDS_DI_DATA;
         default:                       return TMDS_CONTROL;
      endcase
   endfunction

endpackage

// File: rtl/data_island_scheduler_if.sv
// Packet source bus: per-source valid/header/subpackets into the scheduler, pop pulses back.
interface data_island_scheduler_if #(parameter int NUM_SRC = 4) ();
   logic [NUM_SRC-1:0]            src_valid;
   logic [NUM_SRC-1:0][23:0]      src_header;
   logic [NUM_SRC-1:0][3:0][55:0] src_sub;
   logic [NUM_SRC-1:0]            src_ready;

   modport master (output src_valid, output src_header, output src_sub, input src_ready);
   modport slave  (input src_valid, input src_header, input src_sub, output src_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter  int NUM_SRC = 4,
   localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int j;
      logic [IDX_W-1:0] jj;
      j   = 0;
      jj  = '0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_SRC) j = j - NUM_SRC;
         jj = IDX_W'(j);
         if (!any && req[jj]) begin
            any     = 1'b1;
            gnt[jj] = 1'b1;
            idx     = jj;
         end
      end
   end

endmodule

// File: rtl/data_island_scheduler.sv
// Sequences HDMI data islands inside horizontal blanking and feeds granted packets
// from NUM_SRC sources to the packet assembler, one 32-cycle slot per packet.
module data_island_scheduler
   import hdmi_pkg::*;
#(
   parameter int NUM_SRC       = 4,
   parameter int MAX_PACKETS   = DI_MAX_PACKETS,
   parameter int CTRL_LEAD     = 4,
   parameter int TRAIL_RESERVE = 22
) (
   input  logic                    clk_pixel,
   input  logic                    reset_n,
   input  logic                    blank_start,
   input  logic [11:0]             blank_len,
   data_island_scheduler_if.slave  src,
   output logic [1:0]              tmds_mode,
   output logic                    data_island_period,
   output logic [23:0]             header,
   output logic [3:0][55:0]        sub,
   output logic [4:0]              pkt_count
);

   localparam int IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int OVERHEAD = CTRL_LEAD + PREAMBLE_LEN + 2 * GUARD_LEN + TRAIL_RESERVE;

   // Whole packet slots that fit after leading/trailing overheads, capped at the island limit.
   function automatic logic [4:0] calc_slots(input logic [11:0] len);
      logic [12:0] diff;
      logic [12:0] fit;
      diff = {1'b0, len} - 13'(OVERHEAD);
      fit  = ({1'b0, len} < 13'(OVERHEAD)) ? 13'd0 : (diff >> 5);
      return (fit > 13'(MAX_PACKETS)) ? 5'(MAX_PACKETS) : fit[4:0];
   endfunction

   di_state_t          state, state_n;
   logic [7:0]         cnt, cnt_n;
   logic [4:0]         slot_cnt, slot_cnt_n;
   logic [4:0]         slots_left, slots_left_n;
   logic [4:0]         pkt_count_n;
   logic [IDX_W-1:0]   ptr, ptr_n;
   logic [4:0]         budget;
   logic               grant;
   logic [NUM_SRC-1:0] gnt_oh;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;

   assign budget = calc_slots(blank_len);

   rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
      .req (src.src_valid),
      .ptr (ptr),
      .gnt (gnt_oh),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      slot_cnt_n   = slot_cnt;
      slots_left_n = slots_left;
      pkt_count_n  = pkt_count;
      ptr_n        = ptr;
      grant        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (blank_start && (budget != 5'd0) && (|src.src_valid)) begin
               state_n      = ST_LEAD;
               cnt_n        = '0;
               slots_left_n = budget;
               pkt_count_n  = '0;
            end
         end
         ST_LEAD: begin
            if (cnt == 8'(CTRL_LEAD - 1)) begin
               state_n = ST_PREAMBLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_PREAMBLE: begin
            if (cnt == 8'(PREAMBLE_LEN - 1)) begin
               state_n = ST_GUARD_LEAD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_GUARD_LEAD: begin
            if (cnt == 8'(GUARD_LEN - 1)) begin
               cnt_n      = '0;
               slot_cnt_n = '0;
               // A requester that dropped valid before the first slot leaves the island empty.
               if (gnt_any) begin
                  grant   = 1'b1;
                  state_n = ST_PACKET;
               end else begin
                  state_n = ST_GUARD_TRAIL;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         ST_PACKET: begin
            slot_cnt_n = slot_cnt + 5'd1;
            if (slot_cnt == 5'(PACKET_LEN - 1)) begin
               if ((slots_left != 5'd0) && gnt_any) begin
                  grant = 1'b1;
               end else begin
                  state_n = ST_GUARD_TRAIL;
               end
            end
         end
         ST_GUARD_TRAIL: begin
            if (cnt == 8'(GUARD_LEN - 1)) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (grant) begin
         slots_left_n = slots_left - 5'd1;
         pkt_count_n  = pkt_count + 5'd1;
         ptr_n        = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         slot_cnt      <= '0;
         slots_left    <= '0;
         pkt_count     <= '0;
         ptr           <= '0;
         src.src_ready <= '0;
         header        <= '0;
         sub           <= '0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         slot_cnt      <= slot_cnt_n;
         slots_left    <= slots_left_n;
         pkt_count     <= pkt_count_n;
         ptr           <= ptr_n;
         src.src_ready <= grant ? gnt_oh : '0;
         if (grant) begin
            header <= src.src_header[gnt_idx];
            sub    <= src.src_sub[gnt_idx];
         end
      end
   end

   assign tmds_mode          = state_mode(state);
   assign data_island_period = (state == ST_PACKET);

endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
- Sequences HDMI data-island periods inside horizontal blanking and arbitrates NUM_SRC packet sources (audio sample, ACR, AVI/audio InfoFrames) onto the single downstream packet assembler.
- Drives the TMDS period mode (control / preamble / guard / data) and the assembler's `data_island_period`, `header` and `sub` inputs.
- Holds each granted packet stable for its 32-cycle slot.

Parameters:
- NUM_SRC, 4, number of packet requesters; index 0 has highest initial round-robin priority.
- MAX_PACKETS, 18, maximum packets per island (HDMI limit).
- CTRL_LEAD, 4, control-period cycles between `blank_start` and the preamble.
- TRAIL_RESERVE, 22, cycles reserved after the trailing guard: 12 control, 8 video preamble, 2 video guard.

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- blank_start  in  1  one-cycle pulse on the first cycle of horizontal blanking
- blank_len  in  12  blanking cycles available; sampled with `blank_start`
- src_valid  in  NUM_SRC  per-source packet pending; must hold until acknowledged
- src_header  in  NUM_SRC×24  per-source packet header
- src_sub  in  NUM_SRC×4×56  per-source subpackets
- src_ready  out  NUM_SRC  one-cycle pop pulse when a packet is latched
- tmds_mode  out  2  0=CONTROL, 1=DI_PREAMBLE, 2=DI_GUARD, 3=DI_DATA
- data_island_period  out  1  high exactly while tmds_mode==DI_DATA
- header  out  24  latched header of the current packet
- sub  out  4×56  latched subpackets of the current packet
- pkt_count  out  5  packets sent in the current/last island

Behaviour:
- Reset (asynchronous, active-low) clears everything:
  - state IDLE; tmds_mode=CONTROL; data_island_period=0; header/sub=0; src_ready=0; pkt_count=0.
  - round-robin pointer=0; slot counter=0.
- Budget, computed in IDLE on `blank_start`:
  - fit = (blank_len − (CTRL_LEAD+8+2+2+TRAIL_RESERVE)) >> 5, with CTRL_LEAD+8+2+2+TRAIL_RESERVE = 38 at defaults.
  - fit = 0 if blank_len < 38.
  - slots = min(fit, MAX_PACKETS). Use 13-bit arithmetic for the subtraction.
- Island start:
  - Starts only if slots ≥ 1 and |src_valid. Otherwise stay IDLE.
  - `blank_start` outside IDLE is ignored.
- State sequence (durations in cycles):
  - LEAD, CTRL_LEAD cycles, tmds_mode=CONTROL.
  - PREAMBLE, 8 cycles, mode 1.
  - GUARD_LEAD, 2 cycles, mode 2.
  - PACKET, 32 cycles per packet, mode 3.
  - GUARD_TRAIL, 2 cycles, mode 2.
  - Then IDLE.
- Packet grant:
  - Occurs on the last GUARD_LEAD cycle, and on PACKET cycle 31 when slots_left>0 and any src_valid.
  - Winner is the first valid source at or after the round-robin pointer.
  - On grant: latch src_header/src_sub into header/sub, pulse src_ready[winner] for 1 cycle, set pointer=winner+1 mod NUM_SRC, decrement slots_left, increment pkt_count.
  - If no source is valid at GUARD_LEAD end (a valid dropped illegally), skip PACKET and go to GUARD_TRAIL.
- Packet boundary:
  - At PACKET cycle 31 with no grant (slots exhausted or no valid), next state is GUARD_TRAIL.
  - data_island_period drops on the same edge.
- Slot alignment:
  - The 5-bit slot counter wraps 31→0 exactly in step with the assembler's counter.
  - Both start at 0 on the first DI_DATA cycle; DI_DATA is therefore always a multiple of 32 contiguous cycles.
- Output stability:
  - header/sub change only on grant edges and are stable for all 32 cycles of a slot.
- Latency: first DI_DATA cycle is CTRL_LEAD+8+2+1 = 15 cycles after the `blank_start` cycle.
- pkt_count:
  - Cleared on island start; holds after the island.
  - Saturates at MAX_PACKETS by construction.
- A source that raises valid during an island may be granted in a later slot of the same island.
- Reset mid-island: outputs return immediately to the reset values; no partial packet is resumed.

Decomposition:
- Shared package `hdmi_pkg`:
  - tmds_mode_t enum.
  - State enum.
  - Constants PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, DI_MAX_PACKETS=18.
- One natural sub-module: `rr_arbiter`, parameterised by NUM_SRC. It takes request vector and pointer, and returns one-hot grant and index combinationally.

Test Plan:
- blank_len=138, src_valid=4'b0001 → island starts; GUARD_LEAD→PACKET at cycle 15; 1 packet; src_ready[0] pulses once; data_island_period high 32 cycles; pkt_count=1.
- blank_len=138 (fit=3), all four valid and held → 3 packets granted in order src0, src1, src2; 96 DI_DATA cycles; pointer ends at 3; src3 is granted first in the next island.
- blank_len=37, src_valid=1 → no island; tmds_mode stays CONTROL; src_ready never pulses.
- blank_len=4000, src_valid held high on src2 with re-assert after each ready → exactly 18 packets; then GUARD_TRAIL; pkt_count=18.
- Second `blank_start` during PACKET → ignored; island completes unchanged.
- reset_n asserted at PACKET cycle 10 → next sample: tmds_mode=0, data_island_period=0, header=0; next `blank_start` restarts cleanly with the pointer at 0.
